// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan controller.
//   - FSM state encoding (IDLE / LOAD / SCAN)
//   - default digit count and refresh prescale
//   - width of the digit index buses
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_NUM_DIGITS = 8;      // digits sequenced by default
    localparam int SEG_PRESCALE   = 50000;  // clk cycles per refresh slot
    localparam int SEG_SEL_W      = 3;      // width of digit index buses

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } state_t;

endpackage : seg_pkg

// File: rtl/seg_tick_gen.sv
// -----------------------------------------------------------------------------
// seg_tick_gen
// Free-running prescale counter 0..PRESCALE-1. tick is high during the last
// count of every period, i.e. once every PRESCALE cycles. clr holds the
// counter at 0 (synchronous).
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   clr   in   synchronous clear, counter restarts at 0
//   tick  out  1 while the counter sits at PRESCALE-1
// -----------------------------------------------------------------------------
module seg_tick_gen #(
    parameter int PRESCALE = seg_pkg::SEG_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule : seg_tick_gen

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Sequences the loading of NUM_DIGITS digit registers after a multiplier
// result becomes valid, then time-multiplexes the digits onto the display.
//
//   IDLE : wait for a rising edge on done
//   LOAD : load_en=1, seg_mux_sel steps 0..NUM_DIGITS-1 (one digit per cycle)
//   SCAN : one digit enabled at a time (an active low), advancing every
//          PRESCALE cycles
//
// A done edge during LOAD is remembered in a single pending flag and replays
// the whole LOAD sequence right after the current one. A done edge during
// SCAN restarts LOAD immediately. Every output comes straight from a flop.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   done         in   multiplier result-valid level
//   seg_mux_sel  out  digit index for the segment mux / register load
//   load_en      out  load strobe to the digit registers
//   scan_sel     out  digit index currently displayed
//   an           out  active-low digit enables
//   busy         out  high while loading
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = SEG_NUM_DIGITS,
    parameter int PRESCALE   = SEG_PRESCALE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done,
    output logic [SEG_SEL_W-1:0]  seg_mux_sel,
    output logic                  load_en,
    output logic [SEG_SEL_W-1:0]  scan_sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam logic [SEG_SEL_W-1:0] LAST_DIGIT = SEG_SEL_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_0 = NUM_DIGITS'(1);

    state_t                  state, state_d;
    logic                    done_q1, done_q2;
    logic                    rise;
    logic                    pending, pending_d;
    logic [SEG_SEL_W-1:0]    mux_sel_d, scan_sel_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    tick, tick_clr;

    // Edge detect works on two registered copies of done, so done never
    // reaches an output through logic alone.
    assign rise = done_q1 && !done_q2;

    // The counter is held at 0 whenever we are not in SCAN, and also on the
    // cycle we leave it, so each SCAN entry begins a fresh full slot.
    assign tick_clr = (state != SCAN) || (state_d != SCAN);

    seg_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state;
        pending_d  = pending;
        mux_sel_d  = '0;
        scan_sel_d = scan_sel;

        unique case (state)
            IDLE: begin
                pending_d  = 1'b0;
                scan_sel_d = '0;
                if (rise) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                scan_sel_d = '0;
                if (seg_mux_sel == LAST_DIGIT) begin
                    // An edge arriving on the last cycle counts as pending too.
                    if (pending || rise) begin
                        state_d   = LOAD;
                        pending_d = 1'b0;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    mux_sel_d = seg_mux_sel + SEG_SEL_W'(1);
                    pending_d = pending || rise;
                end
            end

            SCAN: begin
                if (rise) begin
                    state_d    = LOAD;
                    scan_sel_d = '0;
                end else if (tick) begin
                    scan_sel_d = (scan_sel == LAST_DIGIT) ? '0
                                                          : scan_sel + SEG_SEL_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                pending_d  = 1'b0;
                scan_sel_d = '0;
            end
        endcase

        an_d = '1;
        if (state_d == SCAN) begin
            an_d = ~(ONE_HOT_0 << scan_sel_d);
        end
    end

    // Outputs are registered from the next-state values so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            done_q1     <= 1'b0;
            done_q2     <= 1'b0;
            pending     <= 1'b0;
            seg_mux_sel <= '0;
            scan_sel    <= '0;
            an          <= '1;
            load_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            done_q1     <= done;
            done_q2     <= done_q1;
            pending     <= pending_d;
            seg_mux_sel <= mux_sel_d;
            scan_sel    <= scan_sel_d;
            an          <= an_d;
            load_en     <= (state_d == LOAD);
            busy        <= (state_d == LOAD);
        end
    end

endmodule : seg_scan_ctrl

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=4.
// A cycle model (load position, pending flag, cycles spent scanning) predicts
// every output after every clock edge; directed tables and sequences cover
// reset, load, scan, retrigger and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         done = 1'b0;
    logic [2:0]   seg_mux_sel;
    logic         load_en;
    logic [2:0]   scan_sel;
    logic [N-1:0] an;
    logic         busy;

    seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .PRESCALE   (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .seg_mux_sel (seg_mux_sel),
        .load_en     (load_en),
        .scan_sel    (scan_sel),
        .an          (an),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 loading, 2 scanning
    int m_mode, m_pos, m_age;
    bit m_pend, m_h1, m_h2;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_age = 0;
        m_pend = 0; m_h1 = 0; m_h2 = 0;
    endtask

    // One clock edge; d is the done level sampled at that edge.
    task automatic model_step(input logic d);
        bit r;
        r = m_h1 && !m_h2;
        case (m_mode)
            0: if (r) begin m_mode = 1; m_pos = 0; end
            1: begin
                if (m_pos == N - 1) begin
                    if (m_pend || r) begin m_pos = 0; m_pend = 0; end
                    else begin m_mode = 2; m_age = 0; end
                end else begin
                    m_pos++;
                    if (r) m_pend = 1;
                end
            end
            default: begin
                if (r) begin m_mode = 1; m_pos = 0; end
                else m_age++;
            end
        endcase
        m_h2 = m_h1;
        m_h1 = d;
    endtask

    function automatic logic [2:0] m_sel();
        return (m_mode == 2) ? 3'((m_age / P) % N) : 3'd0;
    endfunction

    function automatic logic [3:0] m_an();
        logic [3:0] oh;
        oh = 4'b0001 << m_sel();
        return (m_mode == 2) ? ~oh : 4'hF;
    endfunction

    task automatic compare_model();
        check("mdl_load_en", 32'(load_en), 32'(m_mode == 1));
        check("mdl_busy",    32'(busy),    32'(m_mode == 1));
        check("mdl_mux_sel", 32'(seg_mux_sel), (m_mode == 1) ? 32'(m_pos) : 32'd0);
        check("mdl_scan_sel", 32'(scan_sel), 32'(m_sel()));
        check("mdl_an",      32'(an),      32'(m_an()));
    endtask

    // Apply done for one cycle, step the model at the edge, compare at negedge.
    task automatic cyc(input logic d);
        done = d;
        @(posedge clk);
        model_step(d);
        @(negedge clk);
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mux"},  32'(seg_mux_sel), 32'd0);
        check({tag, "_le"},   32'(load_en),     32'd0);
        check({tag, "_ssel"}, 32'(scan_sel),    32'd0);
        check({tag, "_an"},   32'(an),          32'hF);
        check({tag, "_busy"}, 32'(busy),        32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       d;
        logic       le;
        logic [2:0] mux;
        logic [2:0] ssel;
        logic [3:0] an;
    } vec_t;

    vec_t tbl[22];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp_mux[8];
        int guard;
        bit found;
        logic [3:0] oh;

        // Table: done rises on row 0 and stays high. LOAD on rows 1..4,
        // SCAN from row 5, each digit held P cycles, wrap at row 21.
        tbl[0] = '{d: 1'b1, le: 1'b0, mux: 3'd0, ssel: 3'd0, an: 4'hF};
        for (int i = 1; i <= 4; i++)
            tbl[i] = '{d: 1'b1, le: 1'b1, mux: 3'(i - 1), ssel: 3'd0, an: 4'hF};
        for (int i = 5; i < 22; i++) begin
            oh = 4'b0001 << ((i - 5) / 4) % 4;
            tbl[i] = '{d: 1'b1, le: 1'b0, mux: 3'd0, ssel: 3'(((i - 5) / 4) % 4), an: ~oh};
        end

        // ---- reset state ----
        model_reset();
        @(negedge clk);
        check_reset_values("rst_hold");
        rst = 1'b1;

        // ---- idle with done low for 20 cycles ----
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0);
            check("idle_an", 32'(an), 32'hF);
            check("idle_le", 32'(load_en), 32'd0);
        end

        // ---- load then scan, done held high (no retrigger) ----
        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].d);
            check($sformatf("tbl%0d_le", i),   32'(load_en),     32'(tbl[i].le));
            check($sformatf("tbl%0d_mux", i),  32'(seg_mux_sel), 32'(tbl[i].mux));
            check($sformatf("tbl%0d_ssel", i), 32'(scan_sel),    32'(tbl[i].ssel));
            check($sformatf("tbl%0d_an", i),   32'(an),          32'(tbl[i].an));
        end

        // ---- second edge during LOAD at mux=1 -> back-to-back LOAD ----
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);                         // edge sampled, still scanning
        check("rt_still_scan", 32'(load_en), 32'd0);
        exp_mux = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            cyc((i == 0) ? 1'b0 : 1'b1);   // done drops then rises while mux=1
            check($sformatf("rt_le%0d", i),  32'(load_en),     32'd1);
            check($sformatf("rt_mux%0d", i), 32'(seg_mux_sel), 32'(exp_mux[i]));
        end
        cyc(1'b1);
        check("rt_scan_le", 32'(load_en), 32'd0);
        check("rt_scan_an", 32'(an),      32'hE);

        // ---- edge while scan_sel = 2 -> LOAD, then SCAN from digit 0 ----
        found = 0;
        guard = 0;
        while (!found && guard < 50) begin
            cyc(1'b0);
            guard++;
            if (scan_sel == 3'd2) found = 1;
        end
        check("sc_reach_sel2", 32'(found), 32'd1);
        cyc(1'b1);
        check("sc_sel2_an", 32'(an), 32'hB);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            check($sformatf("sc_ld_an%0d", i),  32'(an),          32'hF);
            check($sformatf("sc_ld_mux%0d", i), 32'(seg_mux_sel), 32'(i));
        end
        cyc(1'b1);
        check("sc_restart_sel", 32'(scan_sel), 32'd0);
        check("sc_restart_an",  32'(an),       32'hE);

        // ---- reset during LOAD at mux=2 ----
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        check("mr_mux2", 32'(seg_mux_sel), 32'd2);
        done = 1'b0;
        rst  = 1'b0;
        #1;
        check_reset_values("mr_async");
        model_reset();
        @(negedge clk);
        check_reset_values("mr_hold");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
            check("mr_no_load", 32'(load_en), 32'd0);
        end

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            logic d;
            d = done;
            if ($urandom_range(0, 5) == 0) d = ~d;
            cyc(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg_scan_ctrl

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001: Parameter NUM_DIGITS, default 8, SHALL be the number of 7-segment digits sequenced (legal 2..8).
REQ-002: Parameter PRESCALE, default 50000, SHALL be the clk cycles per digit refresh slot (legal >= 2).
REQ-003: Port clk, input, 1, SHALL be the single clock; all flops SHALL be clocked on its rising edge.
REQ-004: Port rst, input, 1, SHALL be the reset, asynchronous and active-low.
REQ-005: Port done, input, 1, SHALL be the multiplier result-valid level.
REQ-006: Port seg_mux_sel, output, 3, SHALL be the digit index presented to the segment mux and digit registers during load.
REQ-007: Port load_en, output, 1, SHALL be the load strobe driving the digit registers' done input.
REQ-008: Port scan_sel, output, 3, SHALL be the digit index currently displayed.
REQ-009: Port an, output, NUM_DIGITS, SHALL be the active-low digit enables.
REQ-010: Port busy, output, 1, SHALL be high while in LOAD.

Function
REQ-011: The FSM SHALL have exactly the states IDLE, LOAD and SCAN.
REQ-012: A done rising edge SHALL be detected from a registered copy of done; a level held high SHALL NOT re-trigger.
REQ-013: IDLE -> LOAD SHALL occur on the cycle after a done rising edge is detected.
REQ-014: In LOAD, load_en SHALL be 1 and seg_mux_sel SHALL step 0,1,...,NUM_DIGITS-1, one value per cycle, for exactly NUM_DIGITS cycles.
REQ-015: After the cycle with seg_mux_sel = NUM_DIGITS-1, the FSM SHALL enter SCAN, with load_en = 0 and seg_mux_sel returned to 0.
REQ-016: In SCAN, a prescale counter SHALL count 0..PRESCALE-1 and wrap; on each wrap, scan_sel SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017: In SCAN, an SHALL equal all ones except bit scan_sel, which SHALL be 0; exactly one digit SHALL be enabled.
REQ-018: Outside SCAN, an SHALL be all ones.
REQ-019: A done rising edge in SCAN SHALL move the FSM to LOAD on the next cycle, clearing the prescale counter and scan_sel to 0.
REQ-020: A done rising edge in LOAD SHALL set a pending flag and SHALL NOT disturb the current sequence.
REQ-021: A set pending flag SHALL cause LOAD to restart at seg_mux_sel = 0 immediately after the last LOAD cycle, and SHALL then clear; further edges SHALL be merged into one pending flag.
REQ-022: A done rising edge in the same cycle as the last LOAD cycle SHALL also set pending, and SHALL NOT be lost.
REQ-023: All outputs SHALL be registered, with no combinational path from done to any output.

Reset
REQ-024: While rst = 0: state IDLE, seg_mux_sel = 0, load_en = 0, scan_sel = 0, an = all ones, busy = 0, pending = 0, prescale counter = 0, done history = 0.
REQ-025: A reset asserted mid-LOAD or mid-SCAN SHALL abort the operation immediately; after release, the FSM SHALL wait in IDLE for a new done rising edge.

Structure
REQ-026: The state encoding and the default NUM_DIGITS/PRESCALE constants SHALL live in the shared package seg_pkg.
REQ-027: The prescale counter SHALL be one sub-module, seg_tick_gen (inputs clk, rst, clr; output tick pulsed every PRESCALE cycles).

Verification (bench uses NUM_DIGITS = 4, PRESCALE = 4)
REQ-028: Reset release, done held 0 for 20 cycles -> state IDLE, an = 4'b1111, load_en = 0 throughout.
REQ-029: done 0->1 at cycle T, held high -> load_en = 1 at T+2..T+5 with seg_mux_sel 0,1,2,3; SCAN from T+6; no second LOAD.
REQ-030: In SCAN, run 32 cycles -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
REQ-031: Second done edge during LOAD at seg_mux_sel = 1 -> first LOAD completes (0..3), then a second LOAD 0..3 follows back-to-back, then SCAN.
REQ-032: done edge while SCAN shows scan_sel = 2 -> LOAD next cycle, an = 1111 for 4 cycles, SCAN restarts at scan_sel = 0.
REQ-033: rst pulsed low during LOAD at seg_mux_sel = 2 -> all outputs at reset values within the same cycle; no load_en until a new done edge.
